xadc_drp_writer: RTL and testbench
==================================

# xadc_drp_writer

DRP initiator that issues single register read/write transactions to the XADC Dynamic Reconfiguration Port.
- Used at runtime to change XADC configuration registers: averaging, sequencer channel enables, alarm thresholds.
- Sits between a command source (switch/FSM logic) and the `xadc_wiz_0` DRP pins, ahead of the top-level DRP mux that otherwise carries EOC-driven channel reads.
- Completes every transaction with a one-cycle response. A missing `drdy` is reported as a timeout instead of hanging the block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: cycles to wait for `drdy` before aborting; legal range 2..1023.
- `CNT_W`, 10: timeout counter width; must satisfy 2^`CNT_W` > `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: system clock, also drives XADC `dclk_in`.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 7: DRP register address.
- `cmd_data` in 16: write data; ignored on reads.
- `daddr_out` out 7: to XADC `daddr_in`.
- `di_out` out 16: to XADC `di_in`.
- `den_out` out 1: to XADC `den_in`.
- `dwe_out` out 1: to XADC `dwe_in`.
- `drdy_in` in 1: from XADC `drdy_out`.
- `do_in` in 16: from XADC `do_out`.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 16: read data.
- `rsp_timeout` out 1: transaction aborted; valid with `rsp_valid`.
- `rsp_mismatch` out 1: read-back differed from written data; valid with `rsp_valid`.
- `busy` out 1: a transaction is in flight; the top level uses it to select this block on the DRP mux.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - ISSUE: `den` pulse.
  - WAIT: await `drdy`.
  - RB_ISSUE, RB_WAIT: read-back, only when the readback feature is compiled in.
  - RESP.
- IDLE→ISSUE on `cmd_valid`&`cmd_ready`.
  - Addr, data and write flag are registered at acceptance.
  - Command inputs are ignored after acceptance.
- ISSUE (1 cycle):
  - `den_out`=1.
  - `dwe_out`=`cmd_write`.
  - `daddr_out` and `di_out` are driven from the registers.
  - Next state is WAIT.
- WAIT:
  - `daddr_out`/`di_out` hold their values.
  - `den_out`=0 and `dwe_out`=0.
  - The timeout counter increments each cycle.
  - `drdy_in`=1: capture `do_in`; go to RB_ISSUE (write with readback) or RESP.
  - Counter reaches `TIMEOUT_CYCLES` without `drdy`: set the timeout flag and go to RESP.
- RESP (1 cycle):
  - `rsp_valid`=1, then return to IDLE.
  - `rsp_data` holds its value until the next RESP.
  - `rsp_timeout`/`rsp_mismatch` are meaningful only while `rsp_valid`=1 and are 0 otherwise.
- Write without readback: `rsp_data`=16'h0000.
- Timeout: `rsp_data`=16'h0000 and `rsp_mismatch`=0.
- `drdy_in` asserted outside WAIT/RB_WAIT is ignored, with no state change.
- `drdy_in` on the same cycle the counter hits the limit: `drdy` wins, so `rsp_timeout`=0.
- `busy`=1 in every state except IDLE.
- Reset (any time, including mid-transaction):
  - State goes to IDLE and the counter clears.
  - `den_out`, `dwe_out`, `rsp_*` and `busy` are 0; `daddr_out`/`di_out` are 0.
  - `cmd_ready`=1 the first cycle after reset deasserts.
  - No `den` is re-issued for an aborted transaction.

## Timing
- Acceptance at cycle 0 puts `den_out`=1 at cycle 1.
- `drdy` first seen at cycle k (k≥2) gives `rsp_valid` at cycle k+1.
- Minimum command-to-response is 3 cycles; the next command can be accepted the cycle after RESP.
- Timeout: `rsp_valid` arrives at cycle `TIMEOUT_CYCLES`+2 after acceptance.
- Only one transaction is outstanding; `den_out` is never asserted twice without an intervening `drdy` or timeout.
- All outputs are registered.

## Configuration
Macro `XADC_DRP_READBACK_EN`.
- Defined:
  - After a write's `drdy`, RB_ISSUE pulses `den_out`=1, `dwe_out`=0 to the same address.
  - RB_WAIT has its own fresh timeout window.
  - `rsp_data` = read-back value.
  - `rsp_mismatch` = (read-back ≠ written data).
  - Read-back timeout sets `rsp_timeout`=1 and `rsp_mismatch`=0.
  - Minimum write latency becomes 5 cycles.
- Undefined: the RB states and compare logic are absent, and `rsp_mismatch` is tied to 0.

## Structure
- Package `xadc_drp_pkg`:
  - State enum `drp_state_t`.
  - Address constants `XADC_CFG0`=7'h40, `XADC_CFG1`=7'h41, `XADC_CFG2`=7'h42, `XADC_VAUX15`=7'h1F.
  - Widths `DRP_ADDR_W`=7, `DRP_DATA_W`=16.
- Sub-module `drp_timeout_counter`:
  - Inputs: `clr`, `en`.
  - Output: `expired` when count = `TIMEOUT_CYCLES`.
  - Cleared on every ISSUE/RB_ISSUE.

## Test plan
- Read 7'h1F, responder drives `drdy` 4 cycles after `den` with `do`=16'hABC0 → exactly one `den` with `dwe`=0; `rsp_valid` 1 cycle after `drdy`; `rsp_data`=16'hABC0; flags 0.
- Write 7'h41←16'h2F00, responder stores it → `den`&`dwe` asserted with `daddr`=7'h41, `di`=16'h2F00. With the macro: read-back 16'h2F00, `rsp_mismatch`=0. Without it: `rsp_data`=0.
- Write with the responder returning 16'h2F01 on read-back (macro on) → `rsp_mismatch`=1.
- Responder never drives `drdy`, `TIMEOUT_CYCLES`=8 → `rsp_valid` with `rsp_timeout`=1 at cycle 10 after acceptance; `cmd_ready` high the next cycle.
- `reset` asserted 2 cycles into WAIT, stray `drdy` after release → all outputs 0, no `rsp_valid`, `cmd_ready`=1.
- Back-to-back commands held valid → second accepted the cycle after the first `rsp_valid`; `cmd_ready`=0 while `busy`=1.

Source files
------------

// File: rtl/xadc_drp_writer_pkg.sv
// xadc_drp_pkg: shared DRP widths, XADC register addresses and the writer FSM encoding
//   Optional feature macro: XADC_DRP_READBACK_EN (adds the write read-back states)
//   No ports; imported by the interface, the timeout counter and the top level.
package xadc_drp_pkg;
    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam logic [DRP_ADDR_W-1:0] XADC_CFG0   = 7'h40;
    localparam logic [DRP_ADDR_W-1:0] XADC_CFG1   = 7'h41;
    localparam logic [DRP_ADDR_W-1:0] XADC_CFG2   = 7'h42;
    localparam logic [DRP_ADDR_W-1:0] XADC_VAUX15 = 7'h1F;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
`ifdef XADC_DRP_READBACK_EN
        S_RB_ISSUE = 3'd3,
        S_RB_WAIT  = 3'd4,
`endif
        S_RESP     = 3'd5
    } drp_state_t;
endpackage

// File: rtl/xadc_drp_writer_if.sv
// xadc_drp_writer_if: command, XADC DRP pin and response bundle of the DRP writer
//   cmd_*   : command request/handshake from the command source
//   d*_out  : DRP request pins towards xadc_wiz_0; drdy_in/do_in come back from it
//   rsp_*   : one-cycle completion response; busy selects the writer on the DRP mux
//   master  : command source + XADC side; slave: the writer itself
interface xadc_drp_writer_if;
    import xadc_drp_pkg::*;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [DRP_ADDR_W-1:0] cmd_addr;
    logic [DRP_DATA_W-1:0] cmd_data;
    logic [DRP_ADDR_W-1:0] daddr_out;
    logic [DRP_DATA_W-1:0] di_out;
    logic                  den_out;
    logic                  dwe_out;
    logic                  drdy_in;
    logic [DRP_DATA_W-1:0] do_in;
    logic                  rsp_valid;
    logic [DRP_DATA_W-1:0] rsp_data;
    logic                  rsp_timeout;
    logic                  rsp_mismatch;
    logic                  busy;
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, drdy_in, do_in,
        input  cmd_ready, daddr_out, di_out, den_out, dwe_out,
               rsp_valid, rsp_data, rsp_timeout, rsp_mismatch, busy
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, drdy_in, do_in,
        output cmd_ready, daddr_out, di_out, den_out, dwe_out,
               rsp_valid, rsp_data, rsp_timeout, rsp_mismatch, busy
    );
endinterface

// File: rtl/xadc_drp_writer_timeout_counter.sv
// drp_timeout_counter: counts wait cycles for drdy and flags the abort point
//   clk, reset : clock, asynchronous active-high reset
//   clr        : restart the window (held during each den cycle)
//   en         : a wait cycle is in progress
//   expired    : this wait cycle is the TIMEOUT_CYCLES-th one
module drp_timeout_counter
    import xadc_drp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] r_cnt;
    // Loading 1 on clear makes the count equal the ordinal of the current wait
    // cycle, so the abort decision lands exactly TIMEOUT_CYCLES cycles after den.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= CNT_W'(1);
        else if (en)
            r_cnt <= r_cnt + 1'b1;
    end
    assign expired = en && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
endmodule

// File: rtl/xadc_drp_writer.sv
// xadc_drp_writer: single-transaction XADC DRP initiator with drdy timeout
//   Optional feature macro: XADC_DRP_READBACK_EN (each write is verified by a read-back)
//   clk   : system clock, also the XADC dclk
//   reset : asynchronous active-high reset
//   bus   : xadc_drp_writer_if.slave (command in, DRP pins, response out, busy)
module xadc_drp_writer
    import xadc_drp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic             clk,
    input  logic             reset,
    xadc_drp_writer_if.slave bus
);
    drp_state_t            r_state, w_next;
    logic [DRP_ADDR_W-1:0] r_addr;
    logic [DRP_DATA_W-1:0] r_data, r_rsp_data, w_rsp_data;
    logic                  r_write, r_cmd_ready, r_busy, r_den, r_dwe;
    logic                  r_rsp_valid, r_rsp_timeout, r_rsp_mismatch;
    logic                  w_accept, w_clr, w_en, w_expired, w_keep;
    logic                  w_den, w_dwe, w_rsp_valid, w_rsp_timeout, w_rsp_mismatch;

    assign w_accept = bus.cmd_valid && r_cmd_ready;
`ifdef XADC_DRP_READBACK_EN
    assign w_clr = (r_state == S_ISSUE) || (r_state == S_RB_ISSUE);
    assign w_en  = (r_state == S_WAIT) || (r_state == S_RB_WAIT);
`else
    assign w_clr = r_state == S_ISSUE;
    assign w_en  = r_state == S_WAIT;
`endif

    drp_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_clr),
        .en     (w_en),
        .expired(w_expired)
    );

    // State and every output are flopped here; outputs load their next-state
    // decode so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_den          <= 1'b0;
            r_dwe          <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_rsp_mismatch <= 1'b0;
            r_rsp_data     <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_write        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cmd_ready    <= w_next == S_IDLE;
            r_busy         <= w_next != S_IDLE;
            r_den          <= w_den;
            r_dwe          <= w_dwe;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp_timeout  <= w_rsp_timeout;
            r_rsp_mismatch <= w_rsp_mismatch;
            r_rsp_data     <= w_rsp_data;
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_data  <= bus.cmd_data;
                r_write <= bus.cmd_write;
            end
        end
    end

    // drdy is tested before the timeout so a response on the last cycle wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_ISSUE;
            S_ISSUE:    w_next = S_WAIT;
`ifdef XADC_DRP_READBACK_EN
            S_WAIT:     if (bus.drdy_in) w_next = r_write ? S_RB_ISSUE : S_RESP;
                        else if (w_expired) w_next = S_RESP;
            S_RB_ISSUE: w_next = S_RB_WAIT;
            S_RB_WAIT:  if (bus.drdy_in || w_expired) w_next = S_RESP;
`else
            S_WAIT:     if (bus.drdy_in || w_expired) w_next = S_RESP;
`endif
            default:    w_next = S_IDLE;
        endcase
    end

    // w_keep: whether the drdy that ends the transaction carries data to report
    // (a plain write returns zero data).
    always_comb begin
        w_den          = w_next == S_ISSUE;
        w_dwe          = (w_next == S_ISSUE) && bus.cmd_write;
        w_rsp_valid    = w_next == S_RESP;
        w_rsp_timeout  = w_rsp_valid && !bus.drdy_in;
`ifdef XADC_DRP_READBACK_EN
        w_den          = w_den || (w_next == S_RB_ISSUE);
        w_rsp_mismatch = w_rsp_valid && bus.drdy_in && (r_state == S_RB_WAIT) && (bus.do_in != r_data);
        w_keep         = 1'b1;
`else
        w_rsp_mismatch = 1'b0;
        w_keep         = !r_write;
`endif
        w_rsp_data     = w_rsp_valid ? ((bus.drdy_in && w_keep) ? bus.do_in : '0) : r_rsp_data;
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.busy         = r_busy;
    assign bus.den_out      = r_den;
    assign bus.dwe_out      = r_dwe;
    assign bus.daddr_out    = r_addr;
    assign bus.di_out       = r_data;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_timeout  = r_rsp_timeout;
    assign bus.rsp_mismatch = r_rsp_mismatch;
endmodule

// File: tb/tb_xadc_drp_writer.sv
// tb_xadc_drp_writer: randomized transaction-level check of the XADC DRP writer
module tb_xadc_drp_writer;
    import xadc_drp_pkg::*;
    localparam int T = 8;
`ifdef XADC_DRP_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xadc_drp_writer_if bus();
    xadc_drp_writer #(.TIMEOUT_CYCLES(T), .CNT_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0, errors = 0;
    int cyc = 0;
    logic [15:0] mem [128];
    logic [15:0] drdy_at [int];
    logic        exp_we  [int];
    logic [6:0]  exp_ad  [int];
    logic [15:0] exp_di  [int];
    logic [15:0] er_data [int];
    logic        er_to   [int];
    logic        er_mm   [int];
    int ready_cyc = 0, cur_acc = -10, cur_rsp = -10, last_acc = 0;
    logic [6:0]  cur_addr = '0;
    logic [15:0] cur_di = '0, hold = '0;
    bit in_reset = 1'b1;
    int last_rsp_cyc = 0, last_den_cyc = 0, den_cnt = 0, rsp_cnt = 0;
    logic [15:0] last_data = '0;
    logic last_to = 1'b0, last_mm = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // XADC stand-in: plays back the drdy/do schedule the model laid down
    always @(posedge clk) begin
        #1;
        bus.drdy_in = drdy_at.exists(cyc);
        bus.do_in   = drdy_at.exists(cyc) ? drdy_at[cyc] : 16'($urandom);
    end

    always @(negedge clk) begin : cmp
        bit rv, b;
        if (in_reset) begin
            chk("reset_outs", {bus.den_out, bus.dwe_out, bus.rsp_valid, bus.rsp_timeout, bus.rsp_mismatch,
                               bus.busy, bus.daddr_out, bus.di_out, bus.rsp_data}, 64'd0);
        end else begin
            if (exp_we.exists(cyc)) begin
                cur_addr = exp_ad[cyc];
                cur_di   = exp_di[cyc];
            end
            chk("den", bus.den_out, exp_we.exists(cyc) ? 1 : 0);
            chk("dwe", bus.dwe_out, exp_we.exists(cyc) ? exp_we[cyc] : 1'b0);
            chk("daddr", bus.daddr_out, cur_addr);
            chk("di", bus.di_out, cur_di);
            rv = er_data.exists(cyc);
            if (rv) hold = er_data[cyc];
            chk("rsp_valid", bus.rsp_valid, rv);
            chk("rsp_data", bus.rsp_data, hold);
            chk("rsp_timeout", bus.rsp_timeout, rv ? er_to[cyc] : 1'b0);
            chk("rsp_mismatch", bus.rsp_mismatch, rv ? er_mm[cyc] : 1'b0);
            b = (cyc > cur_acc) && (cyc <= cur_rsp);
            chk("busy", bus.busy, b);
            chk("cmd_ready", bus.cmd_ready, !b);
            if (bus.den_out) begin
                den_cnt++;
                last_den_cyc = cyc;
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                last_data = bus.rsp_data;
                last_to = bus.rsp_timeout;
                last_mm = bus.rsp_mismatch;
            end
        end
    end

    task automatic rsp_exp(input int r, input logic [15:0] d, input logic to, input logic mm);
        er_data[r] = d;
        er_to[r] = to;
        er_mm[r] = mm;
    endtask

    // d1/d2: cycles from den to drdy (0 = never, >T = too late); bad/mask corrupt the read-back
    task automatic send(input logic w, input logic [6:0] a, input logic [15:0] d, input int d1,
                        input int d2, input bit bad, input logic [15:0] mask, input bit stray);
        int k, r, g;
        logic [15:0] rb;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr = a;
        bus.cmd_data = d;
        g = 0;
        while (cyc < ready_cyc && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 1000) chk("accept_bound", 0, 1);
        last_acc = cyc;
        exp_we[cyc+1] = w;
        exp_ad[cyc+1] = a;
        exp_di[cyc+1] = d;
        if (stray) drdy_at[cyc+1] = 16'($urandom);
        if (d1 < 1 || d1 > T) begin
            r = cyc + T + 2;
            rsp_exp(r, 16'h0000, 1'b1, 1'b0);
            if (d1 > T) drdy_at[cyc+1+d1] = 16'($urandom);
        end else begin
            k = cyc + 1 + d1;
            if (!w) begin
                drdy_at[k] = mem[a];
                r = k + 1;
                rsp_exp(r, mem[a], 1'b0, 1'b0);
            end else begin
                mem[a] = d;
                drdy_at[k] = 16'($urandom);
                if (!RB) begin
                    r = k + 1;
                    rsp_exp(r, 16'h0000, 1'b0, 1'b0);
                end else begin
                    exp_we[k+1] = 1'b0;
                    exp_ad[k+1] = a;
                    exp_di[k+1] = d;
                    if (d2 < 1 || d2 > T) begin
                        r = k + T + 2;
                        rsp_exp(r, 16'h0000, 1'b1, 1'b0);
                    end else begin
                        rb = bad ? d ^ mask : d;
                        drdy_at[k+1+d2] = rb;
                        r = k + 2 + d2;
                        rsp_exp(r, rb, 1'b0, bad);
                    end
                end
            end
        end
        cur_acc = cyc;
        cur_rsp = r;
        ready_cyc = r + 1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr = 7'($urandom);
        bus.cmd_data = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr = 7'($urandom);
            bus.cmd_data = 16'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (cyc <= cur_rsp && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        in_reset = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        in_reset = 1'b0;
        exp_we.delete(); exp_ad.delete(); exp_di.delete();
        er_data.delete(); er_to.delete(); er_mm.delete(); drdy_at.delete();
        cur_addr = '0; cur_di = '0; hold = '0;
        cur_acc = -10; cur_rsp = -10; ready_cyc = cyc;
    endtask

    function automatic int pick_d();
        int s = $urandom_range(0, 9);
        return s == 0 ? 0 : s == 1 ? T + 1 : s == 2 ? T : $urandom_range(1, 4);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1);
    end

    initial begin : main
        int a0, dc, rc;
        foreach (mem[i]) mem[i] = 16'($urandom);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_data = '0;
        do_reset(3);
        idle(2);

        mem[XADC_VAUX15] = 16'hABC0;
        dc = den_cnt;
        send(1'b0, XADC_VAUX15, 16'h5555, 4, 0, 1'b0, 16'h0, 1'b0);
        wait_done();
        chk("rd_latency", last_rsp_cyc - last_acc, 6);
        chk("rd_data", last_data, 16'hABC0);
        chk("rd_flags", {last_to, last_mm}, 2'b00);
        chk("rd_den_count", den_cnt - dc, 1);
        idle(2);

        dc = den_cnt;
        send(1'b1, XADC_CFG1, 16'h2F00, 2, 3, 1'b0, 16'h0, 1'b0);
        wait_done();
`ifdef XADC_DRP_READBACK_EN
        chk("wr_latency", last_rsp_cyc - last_acc, 8);
        chk("wr_data", last_data, 16'h2F00);
        chk("wr_den_count", den_cnt - dc, 2);
`else
        chk("wr_latency", last_rsp_cyc - last_acc, 4);
        chk("wr_data", last_data, 16'h0000);
        chk("wr_den_count", den_cnt - dc, 1);
`endif
        chk("wr_flags", {last_to, last_mm}, 2'b00);
        idle(1);

`ifdef XADC_DRP_READBACK_EN
        send(1'b1, XADC_CFG1, 16'h2F00, 1, 1, 1'b1, 16'h0001, 1'b0);
        wait_done();
        chk("rb_mm_data", last_data, 16'h2F01);
        chk("rb_mm_flag", last_mm, 1'b1);
        send(1'b1, XADC_CFG2, 16'h1234, 1, 0, 1'b0, 16'h0, 1'b0);
        wait_done();
        chk("rb_timeout", {last_to, last_mm, last_data}, {2'b10, 16'h0000});
        idle(1);
`endif

        send(1'b0, XADC_CFG0, 16'h0, 0, 0, 1'b0, 16'h0, 1'b1);
        wait_done();
        chk("to_latency", last_rsp_cyc - last_acc, 10);
        chk("to_flags", {last_to, last_mm, last_data}, {2'b10, 16'h0000});
        chk("to_ready_next", bus.cmd_ready, 1'b1);

        send(1'b0, XADC_CFG2, 16'h0, T, 0, 1'b0, 16'h0, 1'b0);
        wait_done();
        chk("edge_drdy_wins", last_to, 1'b0);
        chk("edge_latency", last_rsp_cyc - last_acc, 10);

        send(1'b0, XADC_CFG0, 16'h0, 0, 0, 1'b0, 16'h0, 1'b0);
        a0 = last_acc;
        while (cyc < a0 + 4) begin
            @(posedge clk); #1;
        end
        rc = rsp_cnt;
        do_reset(2);
        drdy_at[cyc+1] = 16'hFFFF;
        drdy_at[cyc+2] = 16'hFFFF;
        idle(T + 4);
        chk("rst_no_rsp", rsp_cnt - rc, 0);

        send(1'b0, XADC_CFG1, 16'h0, 1, 0, 1'b0, 16'h0, 1'b0);
        a0 = last_acc;
        send(1'b0, XADC_CFG2, 16'h0, 2, 0, 1'b0, 16'h0, 1'b0);
        wait_done();
        chk("b2b_second_den", last_den_cyc - a0, 5);

        for (int i = 0; i < 150; i++) begin
            logic [6:0] ad;
            int s;
            s = $urandom_range(0, 4);
            ad = s == 0 ? XADC_CFG0 : s == 1 ? XADC_CFG1 : s == 2 ? XADC_CFG2 : s == 3 ? XADC_VAUX15 : 7'($urandom);
            send(1'($urandom), ad, 16'($urandom), pick_d(), pick_d(), $urandom_range(0, 3) == 0,
                 16'($urandom_range(1, 65535)), $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 3));
        end
        wait_done();
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
